// File: rtl/ads8688_scan_sched.sv
// ads8688_scan_sched
//   Scan scheduler in front of the ADS8688 manual-channel SPI engine.
//   It walks the enabled channels of a pass, one MAN_Ch_n command per frame,
//   and appends a NOOP flush frame at the end. The converter returns each
//   result one frame late, so every result is re-tagged with the channel
//   that was issued on the previous frame. The first result of a pass is
//   pipeline priming and is discarded.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous reset, active-high
//   scan_start_i   1-clk pulse, run one pass (ignored while a pass is running)
//   scan_en_i      level, continuous mode: re-run a pass after each pass_done
//   ch_mask_i      enabled channels, latched at pass start
//   gap_cycles_i   idle clocks between a done edge and the next frame, latched at pass start
//   manchn_start_o 1-clk start pulse to the engine
//   chsel_o        command word, held from manchn_start until the done edge
//   manchn_done_i  engine frame complete (rising edge is the event)
//   ch_data_i      engine result, sampled on the done rising edge
//   res_valid_o    1-clk strobe qualifying res_ch_o/res_data_o
//   res_ch_o       channel the result belongs to
//   res_data_o     conversion result
//   pass_done_o    1-clk strobe at the end of a pass
//   busy_o         high from pass accept until pass_done or timeout abort
//   err_timeout_o  sticky frame timeout, cleared by rst or an accepted pass start
module ads8688_scan_sched #(
  parameter int unsigned NUM_CH      = 8,
  parameter logic [15:0] CMD_BASE    = 16'hC000,
  parameter logic [15:0] NOOP_CMD    = 16'h0000,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scan_start_i,
  input  logic              scan_en_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [15:0]       gap_cycles_i,
  output logic              manchn_start_o,
  output logic [15:0]       chsel_o,
  input  logic              manchn_done_i,
  input  logic [15:0]       ch_data_i,
  output logic              res_valid_o,
  output logic [2:0]        res_ch_o,
  output logic [15:0]       res_data_o,
  output logic              pass_done_o,
  output logic              busy_o,
  output logic              err_timeout_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PICK  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state_q,     state_d;
  logic [NUM_CH-1:0] mask_q,      mask_d;
  logic [15:0]       gap_q,       gap_d;
  logic [15:0]       gap_cnt_q,   gap_cnt_d;
  logic [TW-1:0]     to_cnt_q,    to_cnt_d;
  logic [2:0]        cur_ch_q,    cur_ch_d;
  logic              issued_q,    issued_d;     // a channel was issued in this pass
  logic [2:0]        prev_ch_q,   prev_ch_d;
  logic              prev_valid_q, prev_valid_d;
  logic              flush_q,     flush_d;      // current frame is the NOOP flush
  logic              rearm_q,     rearm_d;      // continuous mode may start a pass
  logic              next_pass_q, next_pass_d;  // GAP precedes a new pass, not a frame
  logic              done_d1_q;
  logic              start_q,     start_d;
  logic [15:0]       chsel_q,     chsel_d;
  logic              res_valid_q, res_valid_d;
  logic [2:0]        res_ch_q,    res_ch_d;
  logic [15:0]       res_data_q,  res_data_d;
  logic              pass_done_q, pass_done_d;
  logic              busy_q,      busy_d;
  logic              err_q,       err_d;

  logic              done_rise_s;
  logic              pick_found_s;
  logic [2:0]        pick_ch_s;
  logic              start_pass_s;

  assign done_rise_s = manchn_done_i & ~done_d1_q;

  // Lowest enabled channel strictly above the last one issued in this pass.
  always_comb begin
    pick_found_s = 1'b0;
    pick_ch_s    = 3'd0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (mask_q[n] && (!issued_q || (3'(n) > cur_ch_q))) begin
        pick_found_s = 1'b1;
        pick_ch_s    = 3'(n);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Scheduler next-state logic.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    to_cnt_d     = to_cnt_q;
    cur_ch_d     = cur_ch_q;
    issued_d     = issued_q;
    prev_ch_d    = prev_ch_q;
    prev_valid_d = prev_valid_q;
    flush_d      = flush_q;
    rearm_d      = rearm_q;
    next_pass_d  = next_pass_q;
    chsel_d      = chsel_q;
    res_ch_d     = res_ch_q;
    res_data_d   = res_data_q;
    busy_d       = busy_q;
    err_d        = err_q;
    start_d      = 1'b0;
    res_valid_d  = 1'b0;
    pass_done_d  = 1'b0;
    start_pass_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (scan_start_i || (scan_en_i && rearm_q)) begin
          start_pass_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PICK: begin
        if (pick_found_s) begin
          chsel_d  = CMD_BASE + {3'b000, pick_ch_s, 10'b00_0000_0000};
          cur_ch_d = pick_ch_s;
          issued_d = 1'b1;
          flush_d  = 1'b0;
          start_d  = 1'b1;
          state_d  = S_ISSUE;
        end else if (prev_valid_q) begin
          chsel_d = NOOP_CMD;
          flush_d = 1'b1;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end else begin
          // Empty mask: the pass ends without a single frame.
          pass_done_d = 1'b1;
          busy_d      = 1'b0;
          rearm_d     = 1'b1;
          gap_cnt_d   = 16'd0;
          if (scan_en_i) begin
            next_pass_d = 1'b1;
            state_d     = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (done_rise_s) begin
          // Data arriving now belongs to the frame issued before this one.
          if (prev_valid_q) begin
            res_valid_d = 1'b1;
            res_ch_d    = prev_ch_q;
            res_data_d  = ch_data_i;
          end else begin
            res_valid_d = 1'b0;
          end
          prev_ch_d    = cur_ch_q;
          prev_valid_d = ~flush_q;
          gap_cnt_d    = 16'd0;
          if (flush_q) begin
            pass_done_d = 1'b1;
            busy_d      = 1'b0;
            rearm_d     = 1'b1;
            if (scan_en_i) begin
              next_pass_d = 1'b1;
              state_d     = S_GAP;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_GAP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          rearm_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_ONE;
        end
      end

      S_GAP: begin
        // GAP always lasts gap+1 clocks so done-to-start spacing is gap+3.
        if (gap_cnt_q == gap_q) begin
          gap_cnt_d = 16'd0;
          if (next_pass_q) begin
            next_pass_d = 1'b0;
            if (scan_en_i) begin
              start_pass_s = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_PICK;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (start_pass_s) begin
      mask_d       = ch_mask_i;
      gap_d        = gap_cycles_i;
      err_d        = 1'b0;
      busy_d       = 1'b1;
      prev_valid_d = 1'b0;
      issued_d     = 1'b0;
      next_pass_d  = 1'b0;
      state_d      = S_PICK;
    end else begin
      mask_d = mask_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      gap_q        <= 16'd0;
      gap_cnt_q    <= 16'd0;
      to_cnt_q     <= '0;
      cur_ch_q     <= 3'd0;
      issued_q     <= 1'b0;
      prev_ch_q    <= 3'd0;
      prev_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      rearm_q      <= 1'b0;
      next_pass_q  <= 1'b0;
      done_d1_q    <= 1'b0;
      start_q      <= 1'b0;
      chsel_q      <= 16'h0000;
      res_valid_q  <= 1'b0;
      res_ch_q     <= 3'd0;
      res_data_q   <= 16'h0000;
      pass_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      gap_q        <= gap_d;
      gap_cnt_q    <= gap_cnt_d;
      to_cnt_q     <= to_cnt_d;
      cur_ch_q     <= cur_ch_d;
      issued_q     <= issued_d;
      prev_ch_q    <= prev_ch_d;
      prev_valid_q <= prev_valid_d;
      flush_q      <= flush_d;
      rearm_q      <= rearm_d;
      next_pass_q  <= next_pass_d;
      done_d1_q    <= manchn_done_i;
      start_q      <= start_d;
      chsel_q      <= chsel_d;
      res_valid_q  <= res_valid_d;
      res_ch_q     <= res_ch_d;
      res_data_q   <= res_data_d;
      pass_done_q  <= pass_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign manchn_start_o = start_q;
  assign chsel_o        = chsel_q;
  assign res_valid_o    = res_valid_q;
  assign res_ch_o       = res_ch_q;
  assign res_data_o     = res_data_q;
  assign pass_done_o    = pass_done_q;
  assign busy_o         = busy_q;
  assign err_timeout_o  = err_q;

endmodule

// File: tb/tb_ads8688_scan_sched.sv
// Testbench for ads8688_scan_sched: an engine model echoes the previous
// command as conversion data, a monitor logs frames/results, and each
// scenario task compares the log against lists derived from the mask.
module tb_ads8688_scan_sched;

  localparam logic [15:0] CMD_BASE = 16'hC000;

  logic        clk = 1'b0;
  logic        rst, scan_start, scan_en;
  logic [7:0]  ch_mask;
  logic [15:0] gap_cycles;
  logic        manchn_start;
  logic [15:0] chsel;
  logic        manchn_done;
  logic [15:0] ch_data;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [15:0] res_data;
  logic        pass_done, busy, err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor log
  int          cyc = 0;
  int          t_done = 0;
  bit          t_done_valid = 1'b0;
  logic [15:0] cmd_q[$];
  logic [18:0] res_q[$];
  int          space_q[$];
  int          pass_cnt = 0;

  // expected lists
  logic [15:0] exp_cmd[$];
  logic [18:0] exp_res[$];

  bit          eng_en = 1'b1;
  logic [15:0] eng_last, eng_cmd;

  ads8688_scan_sched dut (
    .clk_i(clk), .rst_i(rst), .scan_start_i(scan_start), .scan_en_i(scan_en),
    .ch_mask_i(ch_mask), .gap_cycles_i(gap_cycles),
    .manchn_start_o(manchn_start), .chsel_o(chsel),
    .manchn_done_i(manchn_done), .ch_data_i(ch_data),
    .res_valid_o(res_valid), .res_ch_o(res_ch), .res_data_o(res_data),
    .pass_done_o(pass_done), .busy_o(busy), .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;

  // Engine model: answers each start after 2..6 clks with the previous command.
  initial begin
    manchn_done = 1'b0;
    ch_data     = 16'h0000;
    eng_last    = 16'h0000;
    forever begin
      @(negedge clk);
      if (manchn_start && eng_en) begin
        eng_cmd = chsel;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        ch_data      = eng_last;
        eng_last     = eng_cmd;
        manchn_done  = 1'b1;
        t_done       = cyc;
        t_done_valid = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        manchn_done = 1'b0;
      end
    end
  end

  // Monitor: logs DUT activity shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (manchn_start === 1'b1) begin
        cmd_q.push_back(chsel);
        space_q.push_back(t_done_valid ? (cyc - t_done) : -1);
      end
      if (res_valid === 1'b1) res_q.push_back({res_ch, res_data});
      if (pass_done === 1'b1) pass_cnt = pass_cnt + 1;
    end
  end

  task automatic clear_log();
    cmd_q.delete();
    res_q.delete();
    space_q.delete();
    pass_cnt = 0;
  endtask

  // Expected frames/results of one pass: ascending enabled channels, then flush.
  task automatic build_expected(input logic [7:0] m);
    exp_cmd.delete();
    exp_res.delete();
    for (int n = 0; n < 8; n++) begin
      if (m[n]) begin
        exp_cmd.push_back(16'(CMD_BASE + n * 1024));
        exp_res.push_back({3'(n), 16'(CMD_BASE + n * 1024)});
      end
    end
    if (m != 8'h00) exp_cmd.push_back(16'h0000);
  endtask

  // One scan_start pass with a nonzero mask; optionally disturbs mask/start mid-pass.
  task automatic run_pass(input logic [7:0] m, input logic [15:0] g, input bit disturb,
                          input logic [7:0] m_late, input string name);
    bit dist_done;
    dist_done = 1'b0;
    clear_log();
    build_expected(m);
    ch_mask = m;
    gap_cycles = g;
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_accept got %b expected 1", name, busy);
    end
    @(negedge clk);
    n_checks++;
    if (manchn_start !== 1'b1) begin
      n_fail++; $display("FAIL %s start_latency got %b expected 1", name, manchn_start);
    end
    for (int k = 0; k < 3000 && pass_cnt == 0; k++) begin
      @(negedge clk);
      if (disturb && !dist_done && cmd_q.size() >= 2) begin
        ch_mask = m_late;
        scan_start = 1'b1;
        dist_done = 1'b1;
      end else begin
        scan_start = 1'b0;
      end
    end
    scan_start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (pass_cnt !== 1) begin
      n_fail++; $display("FAIL %s pass_done_count got %0d expected 1", name, pass_cnt);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after_pass got %b expected 0", name, busy);
    end
    n_checks++;
    if (cmd_q.size() != exp_cmd.size()) begin
      n_fail++; $display("FAIL %s frame_count got %0d expected %0d", name, cmd_q.size(), exp_cmd.size());
    end else begin
      for (int i = 0; i < exp_cmd.size(); i++) begin
        n_checks++;
        if (cmd_q[i] !== exp_cmd[i]) begin
          n_fail++; $display("FAIL %s chsel[%0d] got %h expected %h", name, i, cmd_q[i], exp_cmd[i]);
        end
      end
    end
    n_checks++;
    if (res_q.size() != exp_res.size()) begin
      n_fail++; $display("FAIL %s result_count got %0d expected %0d", name, res_q.size(), exp_res.size());
    end else begin
      for (int i = 0; i < exp_res.size(); i++) begin
        n_checks++;
        if (res_q[i] !== exp_res[i]) begin
          n_fail++; $display("FAIL %s result[%0d] got ch%0d/%h expected ch%0d/%h", name, i,
                             res_q[i][18:16], res_q[i][15:0], exp_res[i][18:16], exp_res[i][15:0]);
        end
      end
    end
    for (int i = 1; i < space_q.size(); i++) begin
      n_checks++;
      if (space_q[i] !== int'(g) + 3) begin
        n_fail++; $display("FAIL %s spacing[%0d] got %0d expected %0d", name, i, space_q[i], int'(g) + 3);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; scan_start = 1'b0; scan_en = 1'b0; ch_mask = 8'h00; gap_cycles = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({manchn_start, chsel, res_valid, res_ch, res_data, pass_done, busy, err_timeout} !== 40'd0) begin
      n_fail++; $display("FAIL reset outputs got %h expected 0",
                         {manchn_start, chsel, res_valid, res_ch, res_data, pass_done, busy, err_timeout});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({manchn_start, busy, pass_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle got %b expected 000", {manchn_start, busy, pass_done});
    end
  endtask

  task automatic test_basic();
    run_pass(8'b0000_0110, 16'd0, 1'b0, 8'h00, "basic");
  endtask

  task automatic test_empty_mask();
    clear_log();
    ch_mask = 8'h00;
    gap_cycles = 16'd3;
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL empty busy_pulse got %b expected 1", busy);
    end
    @(negedge clk);
    n_checks++;
    if ({pass_done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL empty pass_done/busy got %b expected 10", {pass_done, busy});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (cmd_q.size() != 0 || pass_cnt != 1) begin
      n_fail++; $display("FAIL empty frames/passes got %0d/%0d expected 0/1", cmd_q.size(), pass_cnt);
    end
  endtask

  task automatic test_random_passes();
    run_pass(8'h80, 16'd1, 1'b0, 8'h00, "single_ch");
    run_pass(8'hFF, 16'd0, 1'b0, 8'h00, "all_ch");
    for (int i = 0; i < 6; i++) begin
      run_pass(8'($urandom_range(1, 255)), 16'($urandom_range(0, 5)), 1'b0, 8'h00, "random");
    end
  endtask

  task automatic test_mid_pass_changes();
    run_pass(8'b1001_0001, 16'd2, 1'b1, 8'b0000_0110, "midpass_ignored");
    run_pass(8'b0000_0110, 16'd2, 1'b0, 8'h00, "midpass_next");
  endtask

  task automatic test_continuous();
    clear_log();
    ch_mask = 8'h01;
    gap_cycles = 16'd10;
    @(negedge clk) begin scan_start = 1'b1; scan_en = 1'b1; end
    @(negedge clk) scan_start = 1'b0;
    for (int k = 0; k < 2000 && pass_cnt < 3; k++) @(negedge clk);
    scan_en = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (pass_cnt !== 3) begin
      n_fail++; $display("FAIL continuous pass_count got %0d expected 3", pass_cnt);
    end
    n_checks++;
    if (cmd_q.size() != 6 || res_q.size() != 3) begin
      n_fail++; $display("FAIL continuous frames/results got %0d/%0d expected 6/3", cmd_q.size(), res_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (cmd_q[i] !== ((i % 2 == 0) ? CMD_BASE : 16'h0000)) begin
          n_fail++; $display("FAIL continuous chsel[%0d] got %h", i, cmd_q[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (res_q[i] !== {3'd0, CMD_BASE}) begin
          n_fail++; $display("FAIL continuous result[%0d] got %h expected %h", i, res_q[i], {3'd0, CMD_BASE});
        end
      end
    end
    for (int i = 1; i < space_q.size(); i++) begin
      n_checks++;
      if (space_q[i] !== 13) begin
        n_fail++; $display("FAIL continuous spacing[%0d] got %0d expected 13", i, space_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int waited;
    clear_log();
    eng_en = 1'b0;
    ch_mask = 8'h04;
    gap_cycles = 16'd0;
    @(negedge clk) begin scan_start = 1'b1; scan_en = 1'b1; end
    @(negedge clk) scan_start = 1'b0;
    @(negedge clk);
    waited = 0;
    for (int k = 0; k < 5000 && err_timeout !== 1'b1; k++) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited !== 4097) begin
      n_fail++; $display("FAIL timeout wait_clks got %0d expected 4097", waited);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout busy got %b expected 0", busy);
    end
    repeat (50) @(negedge clk);
    n_checks++;
    if (cmd_q.size() != 1 || res_q.size() != 0 || pass_cnt != 0 || err_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout aftermath frames=%0d res=%0d passes=%0d err=%b expected 1/0/0/1",
                         cmd_q.size(), res_q.size(), pass_cnt, err_timeout);
    end
    scan_en = 1'b0;
    eng_en = 1'b1;
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout err_clear got %b expected 0", err_timeout);
    end
    for (int k = 0; k < 500 && busy === 1'b1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    clear_log();
    ch_mask = 8'b0010_1011;
    gap_cycles = 16'd1;
    @(negedge clk) scan_start = 1'b1;
    @(negedge clk) scan_start = 1'b0;
    for (int k = 0; k < 500 && cmd_q.size() < 2; k++) @(negedge clk);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({manchn_start, chsel, res_valid, res_ch, res_data, pass_done, busy, err_timeout} !== 40'd0) begin
      n_fail++; $display("FAIL rst_midframe outputs got %h expected 0",
                         {manchn_start, chsel, res_valid, res_ch, res_data, pass_done, busy, err_timeout});
    end
    rst = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (cmd_q.size() != 2 || res_q.size() != 0 || pass_cnt != 0) begin
      n_fail++; $display("FAIL rst_midframe aftermath frames=%0d res=%0d passes=%0d expected 2/0/0",
                         cmd_q.size(), res_q.size(), pass_cnt);
    end
    run_pass(8'b0101_0000, 16'd2, 1'b0, 8'h00, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_mask();
    test_random_passes();
    test_mid_pass_changes();
    test_continuous();
    test_timeout();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
